// File: rtl/irq_ctrl.sv
// Interrupt controller: per-source edge/level latching, masking, priority vector and CPU irq.
// Optional IRQ_SYNC_EN adds a 2-flop synchroniser on every src line.
module irq_ctrl #(
  parameter int unsigned NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [3:0]      AD,
  input  logic [7:0]      DI,
  output logic [7:0]      DO,
  input  logic            rw,
  input  logic            cs,
  input  logic [NSRC-1:0] src,
  output logic            irq
);

  logic [NSRC-1:0] s;
  logic [NSRC-1:0] src_prev_q;
  logic [NSRC-1:0] mask_q, mode_q, pending_q, pending_d;
  logic [NSRC-1:0] active, rise, clr, ack, mode_n;
  logic [7:0]      vec, rdata;
  logic [2:0]      idx;
  logic            found, wr, rd;

`ifdef IRQ_SYNC_EN
  logic [NSRC-1:0] sync1_q, sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= src;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = src;
`endif

  function automatic logic [7:0] ext(input logic [NSRC-1:0] v);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < int'(NSRC); i++) r[i] = v[i];
    return r;
  endfunction

  assign wr     = cs & ~rw;
  assign rd     = cs & rw;
  assign active = pending_q & mask_q;
  assign rise   = s & ~src_prev_q;

  // Scan from the top down so the lowest active index ends up selected.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    ack   = '0;
    for (int i = int'(NSRC) - 1; i >= 0; i--) begin
      if (active[i]) begin
        found  = 1'b1;
        idx    = i[2:0];
        ack    = '0;
        ack[i] = 1'b1;
      end
    end
    vec = found ? {5'b0, idx} : 8'h80;
  end

  always_comb begin
    clr = '0;
    if (rd && AD == 4'h3) clr = ack;
    if (wr && AD == 4'h0) clr = clr | DI[NSRC-1:0];
    mode_n = (wr && AD == 4'h2) ? DI[NSRC-1:0] : mode_q;
    pending_d = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      if (!mode_q[i]) begin
        // A bit switching into edge mode starts with an empty latch.
        pending_d[i] = mode_n[i] ? 1'b0 : s[i];
      end else begin
        pending_d[i] = (pending_q[i] & ~clr[i]) | rise[i];
      end
    end
  end

  always_comb begin
    unique case (AD)
      4'h0:    rdata = ext(active);
      4'h1:    rdata = ext(mask_q);
      4'h2:    rdata = ext(mode_q);
      4'h3:    rdata = vec;
      4'h4:    rdata = ext(s);
      default: rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    src_prev_q <= s;
    if (rst) begin
      DO        <= 8'h00;
      irq       <= 1'b0;
      mask_q    <= '0;
      mode_q    <= '0;
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
      mode_q    <= mode_n;
      irq       <= |active;
      if (wr && AD == 4'h1) mask_q <= DI[NSRC-1:0];
      if (rd) DO <= rdata;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl (default build, no synchroniser).
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] AD;
  logic [7:0] DI;
  logic [7:0] DO;
  logic       rw;
  logic       cs;
  logic [7:0] src;
  logic       irq;
  logic [7:0] d;
  int         total  = 0;
  int         passed = 0;

  irq_ctrl #(.NSRC(8)) dut (
    .clk (clk),
    .rst (rst),
    .AD  (AD),
    .DI  (DI),
    .DO  (DO),
    .rw  (rw),
    .cs  (cs),
    .src (src),
    .irq (irq)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic wr_reg(input logic [3:0] a, input logic [7:0] v);
    cs = 1'b1; rw = 1'b0; AD = a; DI = v;
    step();
    cs = 1'b0; rw = 1'b1;
  endtask

  task automatic rd_reg(input logic [3:0] a, output logic [7:0] v);
    cs = 1'b1; rw = 1'b1; AD = a;
    step();
    cs = 1'b0;
    v = DO;
  endtask

  initial begin
    rst = 1'b1; AD = '0; DI = '0; rw = 1'b1; cs = 1'b0; src = '0;
    step(); step();
    rst = 1'b0;

    // 1: reset state
    check("t1_irq", {7'b0, irq}, 8'h00);
    rd_reg(4'h0, d); check("t1_status", d, 8'h00);
    rd_reg(4'h1, d); check("t1_mask", d, 8'h00);
    rd_reg(4'h2, d); check("t1_mode", d, 8'h00);
    rd_reg(4'h3, d); check("t1_vec", d, 8'h80);
    rd_reg(4'h4, d); check("t1_src", d, 8'h00);

    // 2: single edge source, acked through the vector
    wr_reg(4'h1, 8'h01);
    wr_reg(4'h2, 8'h01);
    src = 8'h01; step(); src = 8'h00;
    check("t2_irq_k", {7'b0, irq}, 8'h00);
    step();
    check("t2_irq_k1", {7'b0, irq}, 8'h01);
    rd_reg(4'h3, d); check("t2_vec", d, 8'h00);
    step();
    check("t2_irq_low", {7'b0, irq}, 8'h00);
    rd_reg(4'h0, d); check("t2_status", d, 8'h00);

    // 3: priority ordering of two simultaneous edges
    wr_reg(4'h1, 8'hFF);
    wr_reg(4'h2, 8'hFF);
    src = 8'h24; step(); src = 8'h00;
    rd_reg(4'h3, d); check("t3_vec_a", d, 8'h02);
    rd_reg(4'h3, d); check("t3_vec_b", d, 8'h05);
    check("t3_irq_hold", {7'b0, irq}, 8'h01);
    rd_reg(4'h3, d); check("t3_vec_none", d, 8'h80);
    check("t3_irq_low", {7'b0, irq}, 8'h00);

    // 4: level source ignores W1C
    wr_reg(4'h2, 8'h00);
    wr_reg(4'h1, 8'h08);
    src = 8'h08; step(); step();
    check("t4_irq", {7'b0, irq}, 8'h01);
    wr_reg(4'h0, 8'h08);
    check("t4_irq_w1c", {7'b0, irq}, 8'h01);
    rd_reg(4'h0, d); check("t4_status", d, 8'h08);
    src = 8'h00; step(); step();
    check("t4_irq_low", {7'b0, irq}, 8'h00);
    rd_reg(4'h0, d); check("t4_status_low", d, 8'h00);

    // 5: latched while masked, irq on unmask
    wr_reg(4'h1, 8'h00);
    wr_reg(4'h2, 8'h02);
    src = 8'h02; step(); src = 8'h00; step();
    check("t5_irq_masked", {7'b0, irq}, 8'h00);
    rd_reg(4'h0, d); check("t5_status_masked", d, 8'h00);
    wr_reg(4'h1, 8'h02);
    check("t5_irq_wr_edge", {7'b0, irq}, 8'h00);
    step();
    check("t5_irq_unmask", {7'b0, irq}, 8'h01);

    // 6: new edge wins over simultaneous W1C
    wr_reg(4'h0, 8'h02);
    wr_reg(4'h2, 8'h03);
    wr_reg(4'h1, 8'h01);
    rd_reg(4'h0, d); check("t6_status_clear", d, 8'h00);
    src = 8'h01; step(); src = 8'h00; step();
    check("t6_irq_first", {7'b0, irq}, 8'h01);
    src = 8'h01;
    wr_reg(4'h0, 8'h01);
    src = 8'h00;
    rd_reg(4'h0, d); check("t6_status", d, 8'h01);
    step();
    check("t6_irq", {7'b0, irq}, 8'h01);

    // mid-operation reset
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_irq", {7'b0, irq}, 8'h00);
    rd_reg(4'h1, d); check("rst_mask", d, 8'h00);
    rd_reg(4'h2, d); check("rst_mode", d, 8'h00);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
